fifo_packer: RTL and testbench

Downstream consumer of the `fifo` block. It tracks FIFO occupancy by monitoring the FIFO's push/full/pop traffic, because the FIFO exposes no empty flag. It pops WIDTH-bit words whenever data is present and packing space remains, and assembles PACK consecutive words into one wide word. The wide word is offered to the next stage through a valid/ready handshake.

---
 rtl/fifo_packer.sv | 148 ++++++++++++++
 tb/tb_fifo_packer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packer.sv
// fifo_packer: drains an upstream fifo that has no empty flag by tracking its
// occupancy, and packs PACK consecutive words into one wide valid/ready word.
module fifo_packer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int PACK  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_push,
  input  logic                       fifo_full,
  input  logic [WIDTH-1:0]           fifo_out,
  output logic                       fifo_pop,
  output logic [WIDTH*PACK-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(PACK + 1);
  localparam int DW = WIDTH * PACK;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx_s;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_nx_s;
  logic          pend_r;
  logic          pend_nx_s;
  logic          pop_r;
  logic          pop_nx_s;
  logic          valid_r;
  logic          valid_nx_s;
  logic [DW-1:0] data_r;
  logic [DW-1:0] data_nx_s;
  logic          push_acc_s;

  // Slots still unclaimed once captured words and the in-flight pop are counted.
  function automatic logic has_room(input logic [IW-1:0] idx, input logic pend);
    return (int'(idx) + int'(pend)) < PACK;
  endfunction

  // Occupancy follows the fifo's own acceptance rule: a push into a full fifo
  // only lands when a pop frees the slot on the same edge.
  always_comb begin
    push_acc_s = fifo_push && (!fifo_full || pop_r);
    count_nx_s = count_r;
    if (push_acc_s && !pop_r) begin
      count_nx_s = count_r + CW'(1);
    end else if (!push_acc_s && pop_r) begin
      count_nx_s = count_r - CW'(1);
    end else begin
      count_nx_s = count_r;
    end
  end

  // Packing FSM next state: capture returning words in FILL, hold in HOLD.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    valid_nx_s = valid_r;
    data_nx_s  = data_r;
    case (state_r)
      FILL: begin
        if (pend_r) begin
          for (int i = 0; i < PACK; i++) begin
            if (idx_r == IW'(i)) begin
              data_nx_s[i*WIDTH +: WIDTH] = fifo_out;
            end else begin
              data_nx_s[i*WIDTH +: WIDTH] = data_r[i*WIDTH +: WIDTH];
            end
          end
          idx_nx_s = idx_r + IW'(1);
          if (idx_r == IW'(PACK - 1)) begin
            state_nx_s = HOLD;
            valid_nx_s = 1'b1;
          end else begin
            state_nx_s = FILL;
            valid_nx_s = 1'b0;
          end
        end else begin
          state_nx_s = FILL;
          valid_nx_s = 1'b0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nx_s = FILL;
          idx_nx_s   = '0;
          valid_nx_s = 1'b0;
        end else begin
          state_nx_s = HOLD;
          valid_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = FILL;
        idx_nx_s   = '0;
        valid_nx_s = 1'b0;
      end
    endcase
  end

  // The pop rule is evaluated on next-state values so fifo_pop is a flop that
  // equals the rule applied to the current registered state.
  always_comb begin
    pend_nx_s = pop_r;
    if (!valid_nx_s && (count_nx_s != '0)) begin
      pop_nx_s = has_room(idx_nx_s, pend_nx_s);
    end else begin
      pop_nx_s = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FILL;
      count_r <= '0;
      idx_r   <= '0;
      pend_r  <= 1'b0;
      pop_r   <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      count_r <= count_nx_s;
      idx_r   <= idx_nx_s;
      pend_r  <= pend_nx_s;
      pop_r   <= pop_nx_s;
      valid_r <= valid_nx_s;
      data_r  <= data_nx_s;
    end
  end

  assign fifo_pop  = pop_r;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign count     = count_r;

endmodule

// File: tb/tb_fifo_packer.sv
// Bench for fifo_packer: a queue models the upstream fifo, and expected packed
// words are formed from the sequence of words the fifo accepted.
module tb_fifo_packer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 2;
  localparam int PACK  = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DW    = WIDTH * PACK;

  logic             clk;
  logic             reset;
  logic             fifo_push;
  logic             fifo_full;
  logic [WIDTH-1:0] fifo_out;
  logic             fifo_pop;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] push_word;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] acc_q[$];
  logic [DW-1:0]    got_q[$];

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int cyc = 0;
  int underflow = 0;

  fifo_packer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PACK(PACK)) dut (
    .clk(clk), .reset(reset), .fifo_push(fifo_push), .fifo_full(fifo_full),
    .fifo_out(fifo_out), .fifo_pop(fifo_pop), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected n-th packed word: accepted words n*PACK.., first in the low slot.
  function automatic logic [DW-1:0] exp_pack(input int n);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < PACK; k++)
      if (n * PACK + k < acc_q.size()) v[k*WIDTH +: WIDTH] = acc_q[n*PACK + k];
    return v;
  endfunction

  // One clock of the upstream fifo model; called at posedge+1 after inputs are set.
  task automatic step();
    logic pop_s;
    logic acc_s;
    pop_s = fifo_pop;
    acc_s = fifo_push && ((fq.size() < DEPTH) || pop_s);
    if (!reset && out_valid && out_ready) got_q.push_back(out_data);
    if (!reset && pop_s) pops++;
    @(posedge clk);
    #1;
    if (reset) begin
      fq.delete();
      fifo_out = '0;
    end else begin
      if (pop_s) begin
        if (fq.size() == 0) underflow++;
        else fifo_out = fq.pop_front();
      end
      if (acc_s) begin
        fq.push_back(push_word);
        acc_q.push_back(push_word);
      end
    end
    fifo_full = (fq.size() == DEPTH);
    cyc++;
  endtask

  task automatic assert_reset();
    #2 reset = 1'b1;
    #1;
  endtask

  task automatic finish_reset();
    fq.delete();
    acc_q.delete();
    got_q.delete();
    fifo_out  = '0;
    fifo_full = 1'b0;
    fifo_push = 1'b0;
    step();
    step();
    reset = 1'b0;
    pops = 0;
  endtask

  task automatic apply_reset();
    out_ready = 1'b0;
    assert_reset();
    finish_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fifo_push = 1'b1;
      push_word = WIDTH'($urandom);
      step();
    end
    assert_reset();
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", fifo_pop); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    finish_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (count !== '0) begin errors++; $display("FAIL reset_idle_count: got %0d want 0", count); end
      checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_idle_pop: got %b want 0", fifo_pop); end
    end
    fifo_push = 1'b1;
    push_word = 2'b10;
    step();
    fifo_push = 1'b0;
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL first_push_count: got %0d want 1", count); end
    checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL first_pop_latency: got %b want 1", fifo_pop); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] w [4];
    int first_pop, last_pop, rise, npop, nvalid;
    w = '{2'b01, 2'b10, 2'b11, 2'b01};
    apply_reset();
    out_ready = 1'b1;
    first_pop = -1; last_pop = -1; rise = -1; npop = 0; nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin fifo_push = 1'b1; push_word = w[i]; end
      else begin fifo_push = 1'b0; push_word = '0; end
      step();
      checks++; if (count !== CW'(fq.size())) begin errors++; $display("FAIL basic_count: got %0d want %0d", count, fq.size()); end
      if (fifo_pop === 1'b1) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end
      if (out_valid === 1'b1) begin
        if (rise < 0) rise = cyc;
        nvalid++;
      end
    end
    checks++; if (npop != 4) begin errors++; $display("FAIL basic_pop_count: got %0d want 4", npop); end
    checks++; if (last_pop - first_pop != 3) begin errors++; $display("FAIL basic_pop_run: got span %0d want 3", last_pop - first_pop); end
    checks++; if (rise - first_pop != PACK + 1) begin errors++; $display("FAIL basic_pack_latency: got %0d want %0d", rise - first_pop, PACK + 1); end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", nvalid); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_transfers: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'b01_11_10_01) begin errors++; $display("FAIL basic_data: got %b want 01111001", got_q[0]); end
    end
  endtask

  // Fill one pack plus a full fifo while out_ready is low, then wait for HOLD.
  task automatic fill_and_hold(input string tag);
    int t;
    out_ready = 1'b0;
    for (int i = 0; i < 2 * PACK; i++) begin
      fifo_push = 1'b1;
      push_word = WIDTH'($urandom);
      step();
      checks++; if (count !== CW'(fq.size())) begin errors++; $display("FAIL %s_fill_count: got %0d want %0d", tag, count, fq.size()); end
    end
    fifo_push = 1'b0;
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin step(); t++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_wait_valid: got %b want 1", tag, out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    int t;
    apply_reset();
    fill_and_hold("bp");
    held = out_data;
    checks++; if (held !== exp_pack(0)) begin errors++; $display("FAIL bp_data: got %h want %h", held, exp_pack(0)); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== held) begin errors++; $display("FAIL bp_hold_data: got %h want %h", out_data, held); end
      checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL bp_hold_pop: got %b want 0", fifo_pop); end
      checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL bp_hold_count: got %0d want %0d", count, DEPTH); end
    end
    out_ready = 1'b1;
    step();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_one_transfer: got %0d want 1", got_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
    checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL bp_pop_resume: got %b want 1", fifo_pop); end
    t = 0;
    while (got_q.size() < 2 && t < 30) begin step(); t++; end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL bp_second_pack: got %0d transfers want 2", got_q.size()); end
    else begin
      checks++; if (got_q[1] !== exp_pack(1)) begin errors++; $display("FAIL bp_second_data: got %h want %h", got_q[1], exp_pack(1)); end
    end
  endtask

  task automatic test_simultaneous();
    logic pre;
    int hits, t;
    apply_reset();
    fill_and_hold("sim");
    hits = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      fifo_push = 1'b1;
      push_word = WIDTH'($urandom);
      pre = fifo_pop && fifo_full;
      step();
      checks++; if (count !== CW'(fq.size())) begin errors++; $display("FAIL sim_count: got %0d want %0d", count, fq.size()); end
      if (pre) begin
        hits++;
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL sim_full_hold: got %0d want %0d", count, DEPTH); end
      end
    end
    checks++; if (hits == 0) begin errors++; $display("FAIL sim_no_overlap: got 0 full push+pop edges want >0"); end
    t = 0;
    while ((acc_q.size() % PACK) != 0 && t < 40) begin
      fifo_push = 1'b1;
      push_word = WIDTH'($urandom);
      step();
      t++;
    end
    fifo_push = 1'b0;
    t = 0;
    while (got_q.size() < acc_q.size() / PACK && t < 100) begin step(); t++; end
    checks++; if (got_q.size() != acc_q.size() / PACK) begin errors++; $display("FAIL sim_drain: got %0d packs want %0d", got_q.size(), acc_q.size() / PACK); end
    for (int n = 0; n < got_q.size(); n++) begin
      checks++; if (got_q[n] !== exp_pack(n)) begin errors++; $display("FAIL sim_order[%0d]: got %h want %h", n, got_q[n], exp_pack(n)); end
    end
  endtask

  task automatic test_empty_stall();
    int nvalid, t;
    apply_reset();
    out_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      fifo_push = (i < 2);
      push_word = WIDTH'($urandom);
      step();
      if (out_valid === 1'b1) nvalid++;
    end
    checks++; if (pops != 2) begin errors++; $display("FAIL stall_pops: got %0d want 2", pops); end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL stall_valid: got %0d valid cycles want 0", nvalid); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL stall_pop_idle: got %b want 0", fifo_pop); end
    checks++; if (count !== '0) begin errors++; $display("FAIL stall_count: got %0d want 0", count); end
    for (int i = 0; i < 2; i++) begin
      fifo_push = 1'b1;
      push_word = WIDTH'($urandom);
      step();
    end
    fifo_push = 1'b0;
    t = 0;
    while (got_q.size() < 1 && t < 20) begin step(); t++; end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL stall_complete: got %0d packs want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp_pack(0)) begin errors++; $display("FAIL stall_data: got %h want %h", got_q[0], exp_pack(0)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] w [4];
    int t;
    w = '{2'b11, 2'b00, 2'b11, 2'b00};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fifo_push = 1'b1;
      push_word = WIDTH'($urandom);
      step();
    end
    fifo_push = 1'b0;
    step();
    checks++; if (pops != 3) begin errors++; $display("FAIL mid_pops: got %0d want 3", pops); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    assert_reset();
    checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_reset_data: got %h want 0", out_data); end
    checks++; if (count !== '0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got count %0d pop %b want 0 0", count, fifo_pop); end
    finish_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fifo_push = 1'b1;
      push_word = w[i];
      step();
    end
    fifo_push = 1'b0;
    t = 0;
    while (got_q.size() < 1 && t < 20) begin step(); t++; end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL mid_transfers: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'b00_11_00_11) begin errors++; $display("FAIL mid_data: got %b want 00110011", got_q[0]); end
    end
  endtask

  task automatic test_random();
    logic hold_prev;
    logic [DW-1:0] prev;
    int t;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      fifo_push = ($urandom_range(0, 1) == 1);
      push_word = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      hold_prev = out_valid && !out_ready;
      prev = out_data;
      step();
      checks++; if (count !== CW'(fq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count, fq.size()); end
      if (hold_prev) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev) begin errors++; $display("FAIL rnd_hold@%0d: got %b/%h want 1/%h", cyc, out_valid, out_data, prev); end
      end
    end
    out_ready = 1'b1;
    t = 0;
    while ((acc_q.size() % PACK) != 0 && t < 40) begin
      fifo_push = 1'b1;
      push_word = WIDTH'($urandom);
      step();
      t++;
    end
    fifo_push = 1'b0;
    t = 0;
    while (got_q.size() < acc_q.size() / PACK && t < 100) begin step(); t++; end
    checks++; if (got_q.size() != acc_q.size() / PACK) begin errors++; $display("FAIL rnd_drain: got %0d packs want %0d", got_q.size(), acc_q.size() / PACK); end
    for (int n = 0; n < got_q.size(); n++) begin
      checks++; if (got_q[n] !== exp_pack(n)) begin errors++; $display("FAIL rnd_order[%0d]: got %h want %h", n, got_q[n], exp_pack(n)); end
    end
    checks++; if (underflow != 0) begin errors++; $display("FAIL pop_on_empty: got %0d underflows want 0", underflow); end
  endtask

  initial begin
    reset     = 1'b0;
    fifo_push = 1'b0;
    fifo_full = 1'b0;
    fifo_out  = '0;
    out_ready = 1'b0;
    push_word = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_empty_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
